i2c_byte_master: RTL and testbench
==================================

Name: i2c_byte_master

Overview:
- Synthesizable byte-level I2C master that generates SCL and drives SDA toward the slave-side bus functional model on the shared open-drain scl/sda wires.
- Accepts one command at a time from an upstream command/response port: START, STOP, WRITE byte, READ with ACK, READ with NAK.
- Serializes each command onto the bus, then returns one response with read data or the slave's ACK/NAK.
- Supports repeated START and slave clock stretching.

Parameters:
- Q_DIV, 4: system clocks per SCL quarter-bit; minimum 2.
- DATA_WIDTH, 8: byte width on the bus.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid&&ready at a rising clk_i edge.
- cmd_i  in  3  0=START, 1=STOP, 2=WRITE, 3=READ_ACK, 4=READ_NAK; 5-7 illegal.
- wdata_i  in  DATA_WIDTH  byte for WRITE; sampled at accept.
- rsp_valid_o  out  1  one-cycle response strobe.
- rdata_o  out  DATA_WIDTH  read byte; valid with rsp_valid_o after READ_*.
- nak_o  out  1  slave NAK on WRITE; valid with rsp_valid_o.
- err_o  out  1  illegal or out-of-sequence command; valid with rsp_valid_o.
- busy_o  out  1  high between START completion and STOP completion (bus owned).
- scl_i, sda_i  in  1  synchronized bus levels.
- scl_oe_o, sda_oe_o  out  1  1 = pull line low, 0 = release.

Behaviour:
- Reset values: scl_oe_o=0, sda_oe_o=0, cmd_ready_o=1, rsp_valid_o=0, rdata_o=0, nak_o=0, err_o=0, busy_o=0; FSM=IDLE.
- Reset mid-operation releases both lines immediately. No STOP is generated.
- FSM states: IDLE, START_S, STOP_S, BIT, RESP.
- cmd_ready_o is high only in IDLE. Accepting a command moves the FSM to its state.
- A quarter counter counts Q_DIV clocks per quarter; Qn denotes quarter n of a sequence.
- START (legal always; repeated START when busy_o=1): Q0 sda release, scl held low if busy else released; Q1 scl release; Q2 sda low with scl high (START condition); Q3 scl low. busy_o is set at end.
- STOP (legal only if busy_o=1): Q0 sda low, scl low; Q1 scl release; Q2 sda release with scl high (STOP condition); Q3 hold both released. busy_o is cleared at end.
- Byte (WRITE/READ_*, legal only if busy_o=1): 9 bit slots, MSB first.
- Each bit slot: Q0 scl low, set sda; Q1 release scl; Q2 scl high; sample sda_i on the last clock of Q2; Q3 scl low.
- WRITE: slots 1-8 drive wdata bits (0 -> sda_oe=1). Slot 9 releases sda; sampled 1 -> nak_o=1.
- READ: slots 1-8 release sda and shift samples into rdata_o. Slot 9 drives sda low for READ_ACK, releases it for READ_NAK. nak_o=0.
- Clock stretching: in Q1 the quarter counter holds at 0 while scl_i=0 after release. The counter starts counting once scl_i=1. No timeout.
- Latency with no stretching: rsp_valid_o pulses exactly 4*Q_DIV+1 cycles after accept for START/STOP, and 36*Q_DIV+1 cycles after accept for bytes. FSM returns to IDLE in the same cycle.
- Illegal cmd (5-7), or STOP/WRITE/READ while busy_o=0: no bus activity. rsp_valid_o=1 and err_o=1 on the next cycle. Lines and busy_o are unchanged.
- rdata_o and nak_o hold their values until the next response. err_o is 0 for legal commands.
- cmd_valid_i while not ready is ignored; the command must be held by upstream.
- Line ownership: sda_oe_o changes only while scl is low, except the START/STOP edges in Q2.

Test Plan:
- Reset, then START with Q_DIV=4 -> SDA falls while SCL high at quarter 2; rsp_valid_o at cycle 17; busy_o=1; err_o=0.
- START, WRITE 0x44, slave ACKs -> bits 0,1,0,0,0,1,0,0 observed on rising SCL; nak_o=0; rsp_valid_o 145 cycles after accept.
- WRITE 0xA5 with slave releasing SDA on the 9th bit -> nak_o=1; next STOP -> SDA rises while SCL high; busy_o=0.
- START, WRITE 0x45, READ_ACK with slave sending 0x3C, READ_NAK with slave sending 0xC3, STOP -> rdata_o=0x3C then 0xC3; master SDA low on 9th bit of first read, released on second.
- Slave holds SCL low 50 cycles during bit 3 of a WRITE -> response delayed exactly 50 cycles; no bit corruption.
- STOP or WRITE from IDLE, or cmd_i=6 -> err_o=1 pulse one cycle after accept; scl/sda untouched. Assert rst_n_i mid-byte -> both oe=0 and cmd_ready_o=1 immediately.

Source files
------------

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: serializes START/STOP/WRITE/READ commands onto open-drain SCL/SDA,
// one command at a time, with repeated START and slave clock stretching.
module i2c_byte_master #(
    parameter int Q_DIV      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [2:0]            cmd_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  nak_o,
    output logic                  err_o,
    output logic                  busy_o,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_oe_o,
    output logic                  sda_oe_o
);
    localparam int QW = (Q_DIV > 1) ? $clog2(Q_DIV) : 1;
    localparam int SW = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] CMD_START    = 3'd0;
    localparam logic [2:0] CMD_STOP     = 3'd1;
    localparam logic [2:0] CMD_WRITE    = 3'd2;
    localparam logic [2:0] CMD_READ_ACK = 3'd3;
    localparam logic [2:0] CMD_READ_NAK = 3'd4;

    typedef enum logic [2:0] {IDLE, START_S, STOP_S, BIT, RESP} state_t;

    state_t                state, state_nxt;
    logic [QW-1:0]         qcnt;
    logic [1:0]            quarter;
    logic [SW-1:0]         slot;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] wbyte;
    logic [DATA_WIDTH-1:0] rbyte;
    logic                  ack_bit;
    logic                  err_flag;
    logic                  scl_hold;
    logic                  sda_hold;
    logic                  active;
    logic                  accept;
    logic                  cmd_err;
    logic                  stretch;
    logic                  qend;
    logic                  seq_done;

    assign active   = state inside {START_S, STOP_S, BIT};
    assign accept   = cmd_valid_i && (state == IDLE);
    assign cmd_err  = (cmd_i > CMD_READ_NAK) || ((cmd_i != CMD_START) && !busy_o);
    // A slave holding SCL low after we released it freezes the quarter at its first clock.
    assign stretch  = (quarter == 2'd1) && !scl_i;
    assign qend     = (qcnt == QW'(Q_DIV - 1)) && !stretch;
    assign seq_done = qend && (quarter == 2'd3) &&
                      ((state != BIT) || (slot == SW'(DATA_WIDTH)));

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_err)                  state_nxt = RESP;
                    else if (cmd_i == CMD_START)  state_nxt = START_S;
                    else if (cmd_i == CMD_STOP)   state_nxt = STOP_S;
                    else                          state_nxt = BIT;
                end
            end
            START_S, STOP_S, BIT: if (seq_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so the partial case arms cannot infer latches.
    always_comb begin
        cmd_ready_o = (state == IDLE);
        scl_oe_o    = scl_hold;
        sda_oe_o    = sda_hold;
        case (state)
            START_S: begin
                case (quarter)
                    2'd0:    begin scl_oe_o = busy_o; sda_oe_o = 1'b0; end
                    2'd1:    begin scl_oe_o = 1'b0;   sda_oe_o = 1'b0; end
                    2'd2:    begin scl_oe_o = 1'b0;   sda_oe_o = 1'b1; end
                    default: begin scl_oe_o = 1'b1;   sda_oe_o = 1'b1; end
                endcase
            end
            STOP_S: begin
                case (quarter)
                    2'd0:    begin scl_oe_o = 1'b1; sda_oe_o = 1'b1; end
                    2'd1:    begin scl_oe_o = 1'b0; sda_oe_o = 1'b1; end
                    default: begin scl_oe_o = 1'b0; sda_oe_o = 1'b0; end
                endcase
            end
            BIT: begin
                scl_oe_o = (quarter == 2'd0) || (quarter == 2'd3);
                if (slot == SW'(DATA_WIDTH)) sda_oe_o = (op == CMD_READ_ACK);
                else                         sda_oe_o = (op == CMD_WRITE) && !wbyte[DATA_WIDTH-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            qcnt     <= '0;
            quarter  <= '0;
            slot     <= '0;
            op       <= CMD_START;
            wbyte    <= '0;
            rbyte    <= '0;
            ack_bit  <= 1'b0;
            err_flag <= 1'b0;
            scl_hold <= 1'b0;
            sda_hold <= 1'b0;
        end else if (accept) begin
            qcnt     <= '0;
            quarter  <= '0;
            slot     <= '0;
            op       <= cmd_i;
            wbyte    <= wdata_i;
            err_flag <= cmd_err;
        end else if (active) begin
            // Remember the last driven levels so the bus stays put between commands.
            scl_hold <= scl_oe_o;
            sda_hold <= sda_oe_o;
            if ((state == BIT) && (quarter == 2'd2) && qend) begin
                if (slot == SW'(DATA_WIDTH)) ack_bit <= sda_i;
                else                         rbyte   <= {rbyte[DATA_WIDTH-2:0], sda_i};
            end
            if (stretch) begin
                qcnt <= '0;
            end else if (qend) begin
                qcnt    <= '0;
                quarter <= quarter + 2'd1;
                if ((quarter == 2'd3) && (state == BIT)) begin
                    slot  <= slot + 1'b1;
                    wbyte <= wbyte << 1;
                end
            end else begin
                qcnt <= qcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_o <= 1'b0;
            rdata_o     <= '0;
            nak_o       <= 1'b0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            rsp_valid_o <= (state == RESP);
            if (state == RESP) begin
                err_o <= err_flag;
                if (!err_flag) begin
                    case (op)
                        CMD_START: busy_o <= 1'b1;
                        CMD_STOP:  busy_o <= 1'b0;
                        CMD_WRITE: nak_o  <= ack_bit;
                        default: begin
                            rdata_o <= rbyte;
                            nak_o   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_byte_master.sv
// Scoreboard bench for i2c_byte_master: a bus-level slave model plus a command-level reference
// model push expectations; a monitor checks every response strobe against them.
module tb_i2c_byte_master;
    localparam int Q        = 4;
    localparam int SEQ_LAT  = 4 * Q + 1;
    localparam int BYTE_LAT = 36 * Q + 1;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [2:0] cmd_i;
    logic [7:0] wdata_i;
    logic       rsp_valid_o;
    logic [7:0] rdata_o;
    logic       nak_o;
    logic       err_o;
    logic       busy_o;
    logic       scl_oe_o;
    logic       sda_oe_o;
    logic       stretch   = 1'b0;
    logic       slave_low = 1'b0;
    logic       scl_bus;
    logic       sda_bus;

    assign scl_bus = !(scl_oe_o || stretch);
    assign sda_bus = !(sda_oe_o || slave_low);

    always #5 clk_i = ~clk_i;

    i2c_byte_master #(.Q_DIV(Q), .DATA_WIDTH(8)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_i       (cmd_i),
        .wdata_i     (wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rdata_o     (rdata_o),
        .nak_o       (nak_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .scl_i       (scl_bus),
        .sda_i       (sda_bus),
        .scl_oe_o    (scl_oe_o),
        .sda_oe_o    (sda_oe_o)
    );

    typedef struct {
        int         due;
        logic       err;
        logic       busy;
        logic       scl_oe;
        logic       sda_oe;
        logic       chk_nak;
        logic       nak;
        logic       chk_rd;
        logic [7:0] rdata;
        logic       chk_bits;
        logic [8:0] bits;
        int         starts;
        int         stops;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model of the bus owner's view
    logic ref_busy = 1'b0;
    logic ref_scl  = 1'b0;
    logic ref_sda  = 1'b0;
    int   ref_starts = 0;
    int   ref_stops  = 0;

    // Bus observer and slave model
    int         starts_seen = 0;
    int         stops_seen  = 0;
    int         mode  = 0;
    logic [7:0] s_tx  = 8'h00;
    logic       s_ack = 1'b1;
    int         s_cnt = 0;
    logic [8:0] obs   = '0;
    int         obs_n = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge sda_bus) if (scl_bus === 1'b1) starts_seen++;
    always @(posedge sda_bus) if (scl_bus === 1'b1) stops_seen++;

    always @(posedge scl_bus) begin
        if (mode != 0) begin
            obs = {obs[7:0], sda_bus};
            obs_n++;
            s_cnt++;
        end
    end

    always @(negedge scl_bus) begin
        if (mode != 0) begin
            if (s_cnt >= 9) begin
                mode      = 0;
                slave_low = 1'b0;
            end else if (mode == 1) begin
                slave_low = (s_cnt == 8) ? s_ack : 1'b0;
            end else begin
                slave_low = (s_cnt < 8) ? !s_tx[7 - s_cnt] : 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_n_i && rsp_valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", rsp_valid_o, 1'b0);
            end else begin
                me = sb.pop_front();
                check("latency", cyc, me.due);
                check("err", err_o, me.err);
                check("busy", busy_o, me.busy);
                check("scl_oe_hold", scl_oe_o, me.scl_oe);
                check("sda_oe_hold", sda_oe_o, me.sda_oe);
                check("start_count", starts_seen, me.starts);
                check("stop_count", stops_seen, me.stops);
                if (me.chk_nak) check("nak", nak_o, me.nak);
                if (me.chk_rd) check("rdata", rdata_o, me.rdata);
                if (me.chk_bits) begin
                    check("bus_bits", obs, me.bits);
                    check("bus_bit_count", obs_n, 9);
                end
            end
        end
    end

    // Called at a falling clk edge; computes the expected response, then presents the command.
    task automatic issue(input logic [2:0] c, input logic [7:0] wd, input logic [7:0] tx,
                         input logic ack, input int extra, input bit wait_rsp);
        exp_t e;
        int   lat;
        for (int i = 0; i < 200 && !cmd_ready_o; i++) @(negedge clk_i);
        check("cmd_ready", cmd_ready_o, 1'b1);
        e = '{default: 0};
        if (c > 3'd4 || (c != 3'd0 && !ref_busy)) begin
            e.err = 1'b1;
            lat   = 1;
        end else begin
            case (c)
                3'd0: begin
                    lat = SEQ_LAT; ref_busy = 1'b1; ref_scl = 1'b1; ref_sda = 1'b1; ref_starts++;
                end
                3'd1: begin
                    lat = SEQ_LAT; ref_busy = 1'b0; ref_scl = 1'b0; ref_sda = 1'b0; ref_stops++;
                end
                3'd2: begin
                    lat = BYTE_LAT + extra;
                    e.chk_nak = 1'b1; e.nak = !ack;
                    e.chk_bits = 1'b1; e.bits = {wd, !ack};
                    ref_sda = 1'b0;
                    s_ack = ack; s_cnt = 0; obs_n = 0; slave_low = 1'b0; mode = 1;
                end
                default: begin
                    lat = BYTE_LAT + extra;
                    e.chk_nak = 1'b1; e.nak = 1'b0;
                    e.chk_rd = 1'b1; e.rdata = tx;
                    e.chk_bits = 1'b1; e.bits = {tx, (c == 3'd4)};
                    ref_sda = (c == 3'd3);
                    s_tx = tx; s_cnt = 0; obs_n = 0; slave_low = !tx[7]; mode = 2;
                end
            endcase
        end
        e.due    = cyc + 1 + lat;
        e.busy   = ref_busy;
        e.scl_oe = ref_scl;
        e.sda_oe = ref_sda;
        e.starts = ref_starts;
        e.stops  = ref_stops;
        sb.push_back(e);
        cmd_valid_i = 1'b1;
        cmd_i       = c;
        wdata_i     = wd;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        cmd_i       = 3'($urandom);
        wdata_i     = 8'($urandom);
        if (wait_rsp) begin
            for (int i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk_i);
            check("rsp_pending", sb.size(), 0);
            sb.delete();
            @(negedge clk_i);
        end
    endtask

    task automatic stretch_bit3(input int accept_edge);
        while (cyc < accept_edge + 12 * Q + 1) @(negedge clk_i);
        stretch = 1'b1;
        while (cyc < accept_edge + 13 * Q + 50) @(negedge clk_i);
        stretch = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] c;
        int         r;
        rst_n_i     = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_i       = 3'd0;
        wdata_i     = 8'h00;
        repeat (3) @(negedge clk_i);
        check("rst_scl_oe", scl_oe_o, 1'b0);
        check("rst_sda_oe", sda_oe_o, 1'b0);
        check("rst_cmd_ready", cmd_ready_o, 1'b1);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_rdata", rdata_o, 8'h00);
        check("rst_nak", nak_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        rst_n_i     = 1'b1;
        starts_seen = 0;
        stops_seen  = 0;
        @(negedge clk_i);

        // Error cases from an idle bus, then the directed command sequences
        issue(3'd1, 8'h00, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd2, 8'h12, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd6, 8'h00, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd0, 8'h00, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd2, 8'h44, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd2, 8'hA5, 8'h00, 1'b0, 0, 1'b1);
        issue(3'd1, 8'h00, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd0, 8'h00, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd2, 8'h45, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd3, 8'h00, 8'h3C, 1'b1, 0, 1'b1);
        issue(3'd4, 8'h00, 8'hC3, 1'b1, 0, 1'b1);
        issue(3'd1, 8'h00, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd0, 8'h00, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd6, 8'h00, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd0, 8'h00, 8'h00, 1'b1, 0, 1'b1);

        // Slave stretches SCL for 50 clocks inside the fourth bit slot
        fork
            stretch_bit3(cyc + 1);
        join_none
        issue(3'd2, 8'h96, 8'h00, 1'b1, 50, 1'b1);
        issue(3'd1, 8'h00, 8'h00, 1'b1, 0, 1'b1);

        for (int n = 0; n < 100; n++) begin
            r = $urandom_range(0, 15);
            if (r < 2)       c = 3'd0;
            else if (r < 4)  c = 3'd1;
            else if (r < 9)  c = 3'd2;
            else if (r < 11) c = 3'd3;
            else if (r < 13) c = 3'd4;
            else             c = 3'($urandom_range(5, 7));
            issue(c, 8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b1);
        end

        // Reset in the middle of a byte releases the bus at once
        issue(3'd0, 8'h00, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd2, 8'h5A, 8'h00, 1'b1, 0, 1'b0);
        repeat (60) @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("midrst_scl_oe", scl_oe_o, 1'b0);
        check("midrst_sda_oe", sda_oe_o, 1'b0);
        check("midrst_cmd_ready", cmd_ready_o, 1'b1);
        check("midrst_busy", busy_o, 1'b0);
        sb.delete();
        mode       = 0;
        slave_low  = 1'b0;
        stretch    = 1'b0;
        ref_busy   = 1'b0;
        ref_scl    = 1'b0;
        ref_sda    = 1'b0;
        @(negedge clk_i);
        rst_n_i     = 1'b1;
        starts_seen = 0;
        stops_seen  = 0;
        ref_starts  = 0;
        ref_stops   = 0;
        @(negedge clk_i);
        issue(3'd2, 8'h33, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd0, 8'h00, 8'h00, 1'b1, 0, 1'b1);
        issue(3'd4, 8'h00, 8'h81, 1'b1, 0, 1'b1);
        issue(3'd1, 8'h00, 8'h00, 1'b1, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
